// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel word buffer downstream of the main-FIFO pop
// flow control. It stores demultiplexed words, returns them on pop with a
// registered read port, and raises pause back-pressure as the buffer fills.
module vc_fifo #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   afull_thr,
  input  logic [ADDR_WIDTH:0]   aempty_thr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  pause,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(Depth);

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_error;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_err_evt;
  logic [ADDR_WIDTH:0]   w_count_d;

  // Status flags depend only on the registered count, never on push/pop.
  assign full         = (r_count == DepthCnt);
  assign empty        = (r_count == '0);
  assign pause        = (r_count >= afull_thr);
  assign almost_empty = (r_count <= aempty_thr);

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign error     = r_error;

  // A push into a full buffer is still accepted when a pop frees a slot
  // in the same cycle; a pop from an empty buffer never bypasses a push.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;
  assign w_err_evt = (push && full && !pop) || (pop && empty);

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    w_count_d = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_d = r_count + (ADDR_WIDTH+1)'(1);
    end else if (!w_push_ok && w_pop_ok) begin
      w_count_d = r_count - (ADDR_WIDTH+1)'(1);
    end
  end

  // Storage array; left unreset since stale words are unreachable.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, registered read port and sticky error flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_count     <= w_count_d;
      r_valid_out <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop_ok) begin
        // Reads the old word even when the same slot is rewritten this edge.
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      if (w_err_evt) begin
        r_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vc_fifo.sv
// tb_vc_fifo: directed and randomized checks of vc_fifo against a queue model.
module tb_vc_fifo;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW:0]   afull_thr = 3'd3;
  logic [AW:0]   aempty_thr = 3'd1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          full;
  logic          empty;
  logic          pause;
  logic          almost_empty;
  logic          error;

  int checks = 0;
  int failures = 0;

  // Reference model: a plain queue of stored words plus output registers.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_valid = 1'b0;
  logic          m_err = 1'b0;

  vc_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .afull_thr    (afull_thr),
    .aempty_thr   (aempty_thr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .pause        (pause),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("valid_out", 32'(valid_out), 32'(m_valid));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("pause", 32'(pause), 32'(n >= int'(afull_thr)));
    chk("almost_empty", 32'(almost_empty), 32'(n <= int'(aempty_thr)));
    chk("error", 32'(error), 32'(m_err));
  endtask

  // Drive one cycle from a negedge, update the model at the posedge,
  // then compare at the following negedge.
  task automatic cycle(input logic p, input logic [DW-1:0] d, input logic po);
    int  n;
    logic push_ok, pop_ok;
    push = p;
    data_in = d;
    pop = po;
    @(posedge clk);
    n = q.size();
    push_ok = p && (n < DEPTH || po);
    pop_ok = po && (n > 0);
    if ((p && n == DEPTH && !po) || (po && n == 0)) m_err = 1'b1;
    m_valid = pop_ok;
    if (pop_ok) m_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted mid low-phase, checked before any edge.
  task automatic do_reset();
    push = 1'b0;
    pop = 1'b0;
    #2;
    reset_L = 1'b0;
    q.delete();
    m_dout = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    #1;
    compare_all();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    compare_all();
    reset_L = 1'b1;

    // Reset with three words stored.
    for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i), 1'b0);
    do_reset();

    // Fill and drain, with pause/almost_empty thresholds 3 and 1.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Overflow: dropped word must never emerge.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i + 8), 1'b0);
    cycle(1'b1, 6'h3F, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Underflow, then full with simultaneous push/pop.
    do_reset();
    cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 6'h05, 1'b1);
    cycle(1'b0, '0, 1'b1);
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i + 16), 1'b0);
    cycle(1'b1, 6'h2A, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

    // Wrap-around with interleaved push/pop.
    do_reset();
    cycle(1'b1, 6'h00, 1'b0);
    for (int i = 1; i <= 9; i++) cycle(1'b1, DW'(i), 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Threshold extremes: 0 forces pause, above depth clears it.
    afull_thr = 3'd0;
    #1 compare_all();
    afull_thr = 3'd5;
    aempty_thr = 3'd0;
    #1 compare_all();

    // Randomized traffic with changing thresholds and one mid-run reset.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        afull_thr = 3'($urandom_range(0, 7));
        aempty_thr = 3'($urandom_range(0, 7));
        #1 compare_all();
      end
      if (k == 300) do_reset();
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
